// File: rtl/shim_avst_sink_fifo.sv
// AVST ready-latency-0 sink feeding a show-ahead FIFO with a sticky underflow flag.
// Define SHIM_AVST_SINK_STATS_EN to add saturating beat_count/stall_count outputs.
`ifndef DC_BSP_PKG_DEFINED
`define DC_BSP_PKG_DEFINED
package dc_bsp_pkg;
    parameter int SHIM_AVST_DATA_WIDTH = 32;
endpackage
`endif

module shim_avst_sink_fifo #(
    parameter int DATA_WIDTH = dc_bsp_pkg::SHIM_AVST_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    snk_valid,
    output logic                    snk_ready,
    input  logic [DATA_WIDTH-1:0]   snk_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    underflow_err
`ifdef SHIM_AVST_SINK_STATS_EN
    ,
    output logic [31:0]             beat_count,
    output logic [31:0]             stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          ready_q, ready_d;
    logic          underflow_q, underflow_d;
    logic          push, pop, is_empty;

    assign is_empty = (fill_q == '0);
    assign push     = snk_valid & ready_q;
    assign pop      = rd_en & ~is_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        underflow_d = underflow_q | (rd_en & is_empty);
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
        // Ready is registered from next fill so it never depends on snk_valid in-cycle.
        ready_d = (fill_d < FW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            ready_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            ready_q     <= ready_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; fill_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= snk_data;
        end
    end

    assign snk_ready     = ready_q;
    assign rd_data       = mem_q[rd_ptr_q];
    assign empty         = is_empty;
    assign fill_level    = fill_q;
    assign underflow_err = underflow_q;

`ifdef SHIM_AVST_SINK_STATS_EN
    logic [31:0] beat_q, beat_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        beat_d  = beat_q;
        stall_d = stall_q;
        if (push && (beat_q != '1)) begin
            beat_d = beat_q + 32'd1;
        end
        if (snk_valid && !ready_q && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            beat_q  <= beat_d;
            stall_q <= stall_d;
        end
    end

    assign beat_count  = beat_q;
    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_shim_avst_sink_fifo.sv
// Directed + randomized bench for shim_avst_sink_fifo against a queue-based model.
// Stats checks are compiled in when SHIM_AVST_SINK_STATS_EN is defined.
module tb_shim_avst_sink_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int FLW   = $clog2(DEPTH) + 1;

    logic            clk;
    logic            reset_n;
    logic            snk_valid;
    logic            snk_ready;
    logic [DW-1:0]   snk_data;
    logic            rd_en;
    logic [DW-1:0]   rd_data;
    logic            empty;
    logic [FLW-1:0]  fill_level;
    logic            underflow_err;
`ifdef SHIM_AVST_SINK_STATS_EN
    logic [31:0]     beat_count;
    logic [31:0]     stall_count;
`endif

    shim_avst_sink_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .snk_valid     (snk_valid),
        .snk_ready     (snk_ready),
        .snk_data      (snk_data),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .fill_level    (fill_level),
        .underflow_err (underflow_err)
`ifdef SHIM_AVST_SINK_STATS_EN
        ,
        .beat_count    (beat_count),
        .stall_count   (stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a queue of beats plus the expected handshake/flag state.
    logic [DW-1:0] q [$];
    logic          ready_exp;
    logic          uf_exp;
    int unsigned   beats_exp;
    int unsigned   stalls_exp;
    int            total;
    int            passed;
    int            failed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("fill_level", 64'(fill_level), 64'(q.size()));
        chk("snk_ready", 64'(snk_ready), 64'(ready_exp));
        chk("underflow_err", 64'(underflow_err), 64'(uf_exp));
        if (q.size() != 0) begin
            chk("rd_data", 64'(rd_data), 64'(q[0]));
        end
`ifdef SHIM_AVST_SINK_STATS_EN
        chk("beat_count", 64'(beat_count), 64'(beats_exp));
        chk("stall_count", 64'(stall_count), 64'(stalls_exp));
`endif
    endtask

    // Drive one cycle's inputs, advance the model at the edge, check just after it.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
        logic do_push, do_pop;
        snk_valid = v;
        snk_data  = d;
        rd_en     = r;
        @(posedge clk);
        if (reset_n) begin
            do_push = v && ready_exp;
            do_pop  = r && (q.size() != 0);
            if (r && q.size() == 0) uf_exp = 1'b1;
            if (v && !ready_exp && stalls_exp != 32'hFFFF_FFFF) stalls_exp++;
            if (do_push && beats_exp != 32'hFFFF_FFFF) beats_exp++;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
            ready_exp = (q.size() < DEPTH);
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        reset_n    = 1'b0;
        snk_valid  = 1'b0;
        rd_en      = 1'b0;
        q.delete();
        ready_exp  = 1'b0;
        uf_exp     = 1'b0;
        beats_exp  = 0;
        stalls_exp = 0;
        #1;
        check_outputs();
        repeat (cycles) @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;
        #1;
        check_outputs();
        cycle(1'b0, '0, 1'b0);
        chk("ready_after_release", 64'(snk_ready), 64'd1);
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        failed     = 0;
        snk_data   = '0;
        snk_valid  = 1'b0;
        rd_en      = 1'b0;
        reset_n    = 1'b0;
        ready_exp  = 1'b0;
        uf_exp     = 1'b0;
        beats_exp  = 0;
        stalls_exp = 0;

        // Reset state
        do_reset(2);
        chk("reset_empty", 64'(empty), 64'd1);

        // Basic flow: 1..5 in, 1..5 out
        for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i), 1'b0);
        for (int i = 1; i <= 5; i++) begin
            chk("basic_order", 64'(rd_data), 64'(i));
            cycle(1'b0, '0, 1'b1);
        end
        chk("basic_empty", 64'(empty), 64'd1);
        chk("basic_fill", 64'(fill_level), 64'd0);

        // Full / backpressure with valid held high
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0);
        chk("full_ready_low", 64'(snk_ready), 64'd0);
        chk("full_fill", 64'(fill_level), 64'(DEPTH));
        cycle(1'b1, 32'hDEAD_0001, 1'b0);
        cycle(1'b1, 32'hDEAD_0002, 1'b1);
        chk("pop_raises_ready", 64'(snk_ready), 64'd1);
        chk("no_same_cycle_accept", 64'(fill_level), 64'(DEPTH - 1));
        cycle(1'b1, 32'hBEEF_0017, 1'b0);
        chk("beat17_accepted", 64'(fill_level), 64'(DEPTH));

        // Drain, refill to 8, then 100 cycles of simultaneous push/pop
        while (q.size() != 0) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, DW'($urandom), 1'b1);
            chk("steady_fill8", 64'(fill_level), 64'd8);
        end
        while (q.size() != 0) cycle(1'b0, '0, 1'b1);

        // Underflow: pop on empty, then flag sticks through 50 good transfers
        cycle(1'b0, '0, 1'b1);
        chk("underflow_set", 64'(underflow_err), 64'd1);
        chk("underflow_fill", 64'(fill_level), 64'd0);
        cycle(1'b1, 32'h0000_A5A5, 1'b0);
        for (int i = 0; i < 50; i++) cycle(1'b1, DW'($urandom), 1'b1);
        chk("underflow_held", 64'(underflow_err), 64'd1);
        do_reset(1);
        chk("underflow_cleared", 64'(underflow_err), 64'd0);

        // Reset mid-stream at fill_level 10
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'($urandom), 1'b0);
        chk("pre_reset_fill10", 64'(fill_level), 64'd10);
        do_reset(1);
        chk("post_reset_fill", 64'(fill_level), 64'd0);

`ifdef SHIM_AVST_SINK_STATS_EN
        // Stats: 16 accepts, 7 stalled cycles, 4 pops, 4 more accepts
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'($urandom), 1'b0);
        chk("stats_beats20", 64'(beat_count), 64'd20);
        chk("stats_stalls7", 64'(stall_count), 64'd7);
`endif

        // Randomized traffic, including wraps, full and empty corners
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            logic v, r;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) < ((i / 150) % 2 == 0 ? 1 : 3));
            cycle(v, DW'($urandom), r);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed still running expected finished");
        $fatal(1, "timeout");
    end

endmodule
